// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I- and D-cache block fills and D-cache write-throughs.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on I/D ties; otherwise D always wins.
module mem_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        fill_we,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;
  localparam logic [2:0] LAST = 3'(WORDS_PER_BLOCK - 1);
  // only a zero-latency memory can return the last word while reads are still being issued
  localparam bit EARLY_DONE = MEM_LATENCY < 1;
  state_t state, nxt;
  logic owner_d, pick_d, active, fill_hit, done, wr, start;
  logic [15:0] base;
  logic [2:0] issue_cnt, ret_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req & ~(i_req & last_d);
  always_ff @(posedge clk or posedge rst)
    if (rst) last_d <= 1'b0;
    else if (state == IDLE && nxt != IDLE) last_d <= pick_d;
`else
  assign pick_d = d_req;
`endif
  assign wr       = state == WRITE;
  assign active   = state == ISSUE || state == DRAIN;
  assign fill_hit = active & mem_valid;
  assign done     = fill_hit & (ret_cnt == LAST);
  assign start    = state == IDLE && nxt == ISSUE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pick_d ? (d_wr ? WRITE : ISSUE) : (i_req ? ISSUE : IDLE);
      WRITE:   nxt = IDLE;
      ISSUE:   nxt = (EARLY_DONE && done) ? IDLE : (issue_cnt == LAST ? DRAIN : ISSUE);
      default: nxt = done ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        owner_d <= pick_d;
        base    <= (pick_d ? d_addr : i_addr) & 16'hFFF0;
      end
      issue_cnt <= start ? 3'd0 : (state == ISSUE ? issue_cnt + 3'd1 : issue_cnt);
      ret_cnt   <= start ? 3'd0 : (fill_hit ? ret_cnt + 3'd1 : ret_cnt);
    end
  assign mem_en    = wr | (state == ISSUE);
  assign mem_wr    = wr;
  assign mem_addr  = wr ? d_addr : (state == ISSUE ? base + {12'd0, issue_cnt, 1'b0} : 16'd0);
  assign mem_wdata = wr ? d_wdata : 16'd0;
  assign i_grant   = active & ~owner_d;
  assign d_grant   = wr | (active & owner_d);
  assign fill_we   = fill_hit;
  assign fill_data = fill_hit ? mem_rdata : 16'd0;
  assign fill_idx  = active ? ret_cnt : 3'd0;
  assign i_done    = done & ~owner_d;
  assign d_done    = wr | (done & owner_d);
  assign busy      = state != IDLE;
endmodule
